// File: rtl/alu_share_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter_if
// Description : Bundles the two requester request/response ports and the
//               shared ALU operand/result bus of alu_share_arbiter.
//               slave  = arbiter side, master = requesters + ALU side.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if #(
    parameter int XPR_LEN      = 64,
    parameter int ALU_OP_WIDTH = 4
);
    // Requester 0
    logic                    req0_valid;
    logic                    req0_ready;
    logic [ALU_OP_WIDTH-1:0] req0_op;
    logic [XPR_LEN-1:0]      req0_rs1;
    logic [XPR_LEN-1:0]      req0_rs2;
    logic                    resp0_valid;
    logic                    resp0_ready;
    logic [XPR_LEN-1:0]      resp0_data;
    // Requester 1
    logic                    req1_valid;
    logic                    req1_ready;
    logic [ALU_OP_WIDTH-1:0] req1_op;
    logic [XPR_LEN-1:0]      req1_rs1;
    logic [XPR_LEN-1:0]      req1_rs2;
    logic                    resp1_valid;
    logic                    resp1_ready;
    logic [XPR_LEN-1:0]      resp1_data;
    // Shared ALU
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [XPR_LEN-1:0]      alu_rs1;
    logic [XPR_LEN-1:0]      alu_rs2;
    logic                    alu_enable;
    logic [XPR_LEN-1:0]      alu_rd;
    // Status
    logic                    busy;
    logic                    owner;

    modport slave (
        input  req0_valid, req0_op, req0_rs1, req0_rs2, resp0_ready,
        input  req1_valid, req1_op, req1_rs1, req1_rs2, resp1_ready,
        input  alu_rd,
        output req0_ready, resp0_valid, resp0_data,
        output req1_ready, resp1_valid, resp1_data,
        output alu_op, alu_rs1, alu_rs2, alu_enable,
        output busy, owner
    );

    modport master (
        output req0_valid, req0_op, req0_rs1, req0_rs2, resp0_ready,
        output req1_valid, req1_op, req1_rs1, req1_rs2, resp1_ready,
        output alu_rd,
        input  req0_ready, resp0_valid, resp0_data,
        input  req1_ready, resp1_valid, resp1_data,
        input  alu_op, alu_rs1, alu_rs2, alu_enable,
        input  busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Shares one registered ALU (1-cycle latency, result cleared
//               when enable is low) between two valid/ready requesters.
//               Sequence per operation: IDLE (accept) -> ISSUE (enable high)
//               -> CAPTURE (sample alu_rd) -> RESP (return to owner).
//               Arbitration is round-robin by default; defining the macro
//               ALU_ARB_FIXED_PRIO_EN makes port 0 win every tie instead.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int XPR_LEN      = 64,
    parameter int ALU_OP_WIDTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    alu_share_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ALU_OP_WIDTH-1:0] r_op;
    logic [XPR_LEN-1:0]      r_rs1;
    logic [XPR_LEN-1:0]      r_rs2;
    logic [XPR_LEN-1:0]      r_buf;
    logic                    r_owner;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic                    r_last_grant;
`endif

    logic w_win0;
    logic w_win1;
    logic w_hs0;
    logic w_hs1;
    logic w_resp_hs;

    // Pick the winner among the valid requesters
    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        w_win0 = bus.req0_valid;
`else
        // On a tie the port that did not win last time goes first
        w_win0 = bus.req0_valid && (!bus.req1_valid || r_last_grant);
`endif
        w_win1 = bus.req1_valid && !w_win0;
    end

    // Ready only while idle; held low during reset so nothing is accepted then
    assign bus.req0_ready = (r_state == S_IDLE) && !rst && w_win0;
    assign bus.req1_ready = (r_state == S_IDLE) && !rst && w_win1;
    assign w_hs0          = bus.req0_valid && bus.req0_ready;
    assign w_hs1          = bus.req1_valid && bus.req1_ready;
    assign w_resp_hs      = (r_state == S_RESP) &&
                            (r_owner ? bus.resp1_ready : bus.resp0_ready);

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_hs0 || w_hs1) w_next = S_ISSUE;
            S_ISSUE:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_RESP;
            S_RESP:    if (w_resp_hs) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // State register; reset aborts any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand latches, owner/grant history and the one-entry response buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_buf   <= '0;
            r_owner <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            if (w_hs0 || w_hs1) begin
                r_op    <= w_hs1 ? bus.req1_op  : bus.req0_op;
                r_rs1   <= w_hs1 ? bus.req1_rs1 : bus.req0_rs1;
                r_rs2   <= w_hs1 ? bus.req1_rs2 : bus.req0_rs2;
                r_owner <= w_hs1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                r_last_grant <= w_hs1;
`endif
            end
            // ALU result is valid during CAPTURE only; it clears afterwards
            if (r_state == S_CAPTURE) begin
                r_buf <= bus.alu_rd;
            end
        end
    end

    // ALU drive straight from the latches, enable only in ISSUE
    assign bus.alu_op     = r_op;
    assign bus.alu_rs1    = r_rs1;
    assign bus.alu_rs2    = r_rs2;
    assign bus.alu_enable = (r_state == S_ISSUE);

    // Response ports: both carry the buffer, only the owner sees valid
    assign bus.resp0_valid = (r_state == S_RESP) && !r_owner;
    assign bus.resp1_valid = (r_state == S_RESP) &&  r_owner;
    assign bus.resp0_data  = r_buf;
    assign bus.resp1_data  = r_buf;

    assign bus.busy  = (r_state != S_IDLE);
    assign bus.owner = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Self-checking bench for alu_share_arbiter. A registered ALU
//               model sits on the ALU bus; a transaction-level reference
//               model predicts every output each cycle; directed sequences
//               pin literal values, then randomized traffic runs.
//               Honours ALU_ARB_FIXED_PRIO_EN for expected arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
    localparam int XPR_LEN      = 64;
    localparam int ALU_OP_WIDTH = 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_BAD = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;
    localparam logic [3:0] OP_SUB = 4'd10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.XPR_LEN(XPR_LEN), .ALU_OP_WIDTH(ALU_OP_WIDTH)) bus ();

    alu_share_arbiter #(.XPR_LEN(XPR_LEN), .ALU_OP_WIDTH(ALU_OP_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] alu_f(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_XOR:  return a ^ b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            default: return 64'd0;
        endcase
    endfunction

    // Registered ALU: result one cycle after enable, zero when disabled
    initial bus.alu_rd = '0;
    always @(posedge clk) begin
        bus.alu_rd <= bus.alu_enable ? alu_f(bus.alu_op, bus.alu_rs1, bus.alu_rs2) : 64'd0;
    end

    // ---------------- reference model (transaction level) ----------------
    int          cyc     = 0;
    bit          m_busy  = 1'b0;
    bit          m_owner = 1'b0;
    bit          m_last  = 1'b1;
    int          m_acc   = 0;
    logic [3:0]  m_op    = '0;
    logic [63:0] m_rs1   = '0;
    logic [63:0] m_rs2   = '0;
    logic [63:0] m_data  = '0;

    always @(negedge clk) begin
        bit e_r0, e_r1, e_en, e_v0, e_v1;
        cyc++;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (!m_busy && !rst) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            e_r0 = bus.req0_valid;
`else
            e_r0 = bus.req0_valid && (!bus.req1_valid || m_last);
`endif
            e_r1 = bus.req1_valid && !e_r0;
        end
        e_en = m_busy && (cyc == m_acc + 1);
        e_v0 = m_busy && (cyc >= m_acc + 3) && !m_owner;
        e_v1 = m_busy && (cyc >= m_acc + 3) &&  m_owner;

        chk("m_busy",        bus.busy,        m_busy);
        chk("m_req0_ready",  bus.req0_ready,  e_r0);
        chk("m_req1_ready",  bus.req1_ready,  e_r1);
        chk("m_alu_enable",  bus.alu_enable,  e_en);
        chk("m_resp0_valid", bus.resp0_valid, e_v0);
        chk("m_resp1_valid", bus.resp1_valid, e_v1);
        if (e_en) begin
            chk("m_alu_op",  bus.alu_op,  m_op);
            chk("m_alu_rs1", bus.alu_rs1, m_rs1);
            chk("m_alu_rs2", bus.alu_rs2, m_rs2);
        end
        if (m_busy) chk("m_owner", bus.owner, m_owner);
        if (e_v0 || e_v1) begin
            chk("m_resp0_data", bus.resp0_data, m_data);
            chk("m_resp1_data", bus.resp1_data, m_data);
        end

        // Advance the model to the state after the coming edge
        if (rst) begin
            m_busy = 1'b0;
            m_last = 1'b1;
        end else if (!m_busy) begin
            if ((e_r0 && bus.req0_valid) || (e_r1 && bus.req1_valid)) begin
                m_busy  = 1'b1;
                m_owner = e_r1;
                m_last  = e_r1;
                m_acc   = cyc;
                m_op    = e_r1 ? bus.req1_op  : bus.req0_op;
                m_rs1   = e_r1 ? bus.req1_rs1 : bus.req0_rs1;
                m_rs2   = e_r1 ? bus.req1_rs2 : bus.req0_rs2;
                m_data  = alu_f(m_op, m_rs1, m_rs2);
            end
        end else if ((cyc >= m_acc + 3) && (m_owner ? bus.resp1_ready : bus.resp0_ready)) begin
            m_busy = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_inputs();
        bus.req0_valid = 0; bus.req0_op = '0; bus.req0_rs1 = '0; bus.req0_rs2 = '0;
        bus.req1_valid = 0; bus.req1_op = '0; bus.req1_rs1 = '0; bus.req1_rs2 = '0;
        bus.resp0_ready = 1; bus.resp1_ready = 1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; clear_inputs();
        @(posedge clk); #1;
        rst = 0;
    endtask

    // Single operation on one port; checks the returned data
    task automatic single(input bit p, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input string nm);
        bit seen;
        @(posedge clk); #1;
        if (p) begin bus.req1_valid = 1; bus.req1_op = op; bus.req1_rs1 = a; bus.req1_rs2 = b; end
        else   begin bus.req0_valid = 1; bus.req0_op = op; bus.req0_rs1 = a; bus.req0_rs2 = b; end
        seen = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (p ? bus.req1_ready : bus.req0_ready) seen = 1;
        end
        chk({nm, "_accept"}, seen, 1'b1);
        @(posedge clk); #1;
        bus.req0_valid = 0; bus.req1_valid = 0;
        seen = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (p ? bus.resp1_valid : bus.resp0_valid) seen = 1;
        end
        chk({nm, "_resp"}, seen, 1'b1);
        if (seen) chk(nm, p ? bus.resp1_data : bus.resp0_data, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        int  grants[$];
        int  gcyc[$];
        bit  seen;
        bit  hs0, hs1;
        clear_inputs();
        rst = 1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",       bus.busy,        1'b0);
        chk("rst_enable",     bus.alu_enable,  1'b0);
        chk("rst_owner",      bus.owner,       1'b0);
        chk("rst_resp0_v",    bus.resp0_valid, 1'b0);
        chk("rst_resp1_v",    bus.resp1_valid, 1'b0);
        chk("rst_alu_op",     bus.alu_op,      4'd0);
        chk("rst_alu_rs1",    bus.alu_rs1,     64'd0);
        chk("rst_alu_rs2",    bus.alu_rs2,     64'd0);
        chk("rst_resp0_data", bus.resp0_data,  64'd0);
        chk("rst_resp1_data", bus.resp1_data,  64'd0);

        // ADD 5+7 on port 0 with exact timing
        @(posedge clk); #1;
        rst = 0;
        bus.req0_valid = 1; bus.req0_op = OP_ADD; bus.req0_rs1 = 64'd5; bus.req0_rs2 = 64'd7;
        @(negedge clk);
        chk("t1_req0_ready", bus.req0_ready, 1'b1);
        chk("t1_req1_ready", bus.req1_ready, 1'b0);
        chk("t1_enable_c0",  bus.alu_enable, 1'b0);
        @(posedge clk); #1;
        bus.req0_valid = 0;
        @(negedge clk);
        chk("t1_enable_c1", bus.alu_enable, 1'b1);
        chk("t1_alu_rs1",   bus.alu_rs1,    64'd5);
        chk("t1_alu_rs2",   bus.alu_rs2,    64'd7);
        @(negedge clk);
        chk("t1_enable_c2", bus.alu_enable,  1'b0);
        chk("t1_valid_c2",  bus.resp0_valid, 1'b0);
        @(negedge clk);
        chk("t1_resp0_valid", bus.resp0_valid, 1'b1);
        chk("t1_resp0_data",  bus.resp0_data,  64'd12);
        chk("t1_resp1_valid", bus.resp1_valid, 1'b0);
        @(posedge clk); #1;

        // Both ports valid continuously: grants every 4 cycles
        do_reset();
        bus.req0_valid = 1; bus.req0_op = OP_ADD; bus.req0_rs1 = 64'd1;  bus.req0_rs2 = 64'd2;
        bus.req1_valid = 1; bus.req1_op = OP_XOR; bus.req1_rs1 = 64'hF0; bus.req1_rs2 = 64'h0F;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.req0_ready) begin grants.push_back(0); gcyc.push_back(i); end
            if (bus.req1_ready) begin grants.push_back(1); gcyc.push_back(i); end
        end
        chk("alt_count", grants.size(), 4);
        for (int i = 0; i < grants.size() && i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            chk("alt_grant", grants[i], 0);
`else
            chk("alt_grant", grants[i], i % 2);
`endif
            chk("alt_cycle", gcyc[i], 4 * i);
        end
        @(posedge clk); #1;
        clear_inputs();

        // Response back-pressure on port 0 while port 1 waits
        do_reset();
        bus.resp0_ready = 0;
        bus.req0_valid = 1; bus.req0_op = OP_AND; bus.req0_rs1 = 64'hF0F0; bus.req0_rs2 = 64'hFF00;
        bus.req1_valid = 1; bus.req1_op = OP_OR;  bus.req1_rs1 = 64'h1;    bus.req1_rs2 = 64'h2;
        @(negedge clk);
        chk("bp_req0_ready", bus.req0_ready, 1'b1);
        @(posedge clk); #1;
        bus.req0_valid = 0;
        seen = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (bus.resp0_valid) seen = 1;
        end
        chk("bp_resp_seen", seen, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_hold_valid", bus.resp0_valid, 1'b1);
            chk("bp_hold_data",  bus.resp0_data,  64'hF000);
            chk("bp_req1_ready", bus.req1_ready,  1'b0);
        end
        @(posedge clk); #1;
        bus.resp0_ready = 1;
        @(negedge clk);
        chk("bp_req1_wait", bus.req1_ready, 1'b0);
        @(negedge clk);
        chk("bp_req1_go", bus.req1_ready, 1'b1);
        @(posedge clk); #1;
        clear_inputs();

        // Reset while in CAPTURE aborts the operation; tie then goes to port 0
        do_reset();
        bus.req0_valid = 1; bus.req0_op = OP_ADD; bus.req0_rs1 = 64'd3; bus.req0_rs2 = 64'd4;
        @(negedge clk);
        chk("ab_accept", bus.req0_ready, 1'b1);
        @(posedge clk); #1;
        bus.req0_valid = 0;
        @(negedge clk);
        chk("ab_issue", bus.alu_enable, 1'b1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        bus.req0_valid = 1; bus.req0_op = OP_SUB; bus.req0_rs1 = 64'd9; bus.req0_rs2 = 64'd1;
        bus.req1_valid = 1; bus.req1_op = OP_SUB; bus.req1_rs1 = 64'd8; bus.req1_rs2 = 64'd1;
        @(negedge clk);
        chk("ab_busy",       bus.busy,        1'b0);
        chk("ab_resp0_v",    bus.resp0_valid, 1'b0);
        chk("ab_resp1_v",    bus.resp1_valid, 1'b0);
        chk("ab_enable",     bus.alu_enable,  1'b0);
        chk("ab_alu_rs1",    bus.alu_rs1,     64'd0);
        chk("ab_resp0_data", bus.resp0_data,  64'd0);
        chk("ab_tie_req0",   bus.req0_ready,  1'b1);
        chk("ab_tie_req1",   bus.req1_ready,  1'b0);
        @(posedge clk); #1;
        clear_inputs();

        // SUB wraparound and unrecognised opcode on port 1
        do_reset();
        single(1'b1, OP_SUB, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, "sub_wrap");
        single(1'b1, OP_BAD, 64'd5, 64'd6, 64'd0, "bad_op");
        single(1'b0, OP_XOR, 64'hAA, 64'h55, 64'hFF, "xor_p0");

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            hs0 = bus.req0_valid && bus.req0_ready;
            hs1 = bus.req1_valid && bus.req1_ready;
            @(posedge clk); #1;
            rst = ($urandom_range(0, 149) == 0);
            if (!bus.req0_valid || hs0) begin
                bus.req0_valid = ($urandom_range(0, 2) != 0);
                bus.req0_op    = 4'($urandom_range(0, 15));
                bus.req0_rs1   = {$urandom, $urandom};
                bus.req0_rs2   = {$urandom, $urandom};
            end
            if (!bus.req1_valid || hs1) begin
                bus.req1_valid = ($urandom_range(0, 2) != 0);
                bus.req1_op    = 4'($urandom_range(0, 15));
                bus.req1_rs1   = {$urandom, $urandom};
                bus.req1_rs2   = {$urandom, $urandom};
            end
            bus.resp0_ready = ($urandom_range(0, 3) != 0);
            bus.resp1_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        rst = 0;
        clear_inputs();
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("end_idle", bus.busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
